// File: rtl/mc_defs.sv
// Shared definitions for the multicycle controller: state encodings,
// opcode/funct constants, datapath select encodings and the decode class.
package mc_defs;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Register destination select
  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;

  // Register write-data select
  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_DM   = 2'd1;
  localparam logic [1:0] M2R_PC4  = 2'd2;

  // Immediate extension
  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  // Next-PC select
  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_BR   = 3'd1;
  localparam logic [2:0] NPC_J    = 3'd2;
  localparam logic [2:0] NPC_JR   = 3'd3;

  // ALU operation
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_OR   = 3'd2;

  // One-hot instruction class; all-zero means illegal
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: Op/funct -> one-hot class + illegal.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic       illegal
);

  // Classify the instruction; anything unrecognised leaves every class bit low
  always_comb begin
    cls = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls      = '0;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls     = '0;
    endcase
    illegal = ~(|cls);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB state machine,
// combinational control outputs, and a retired-instruction counter.
// Memory handshake: an access in FETCH or MEM completes in any cycle where
// mem_ready is 1; while mem_ready is 0 the FSM holds its state.
module multicycle_ctrl
  import mc_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        ALUSrc,
  output logic [1:0]  RegDst,
  output logic [1:0]  Mem2Reg,
  output logic [1:0]  ExtOp,
  output logic [2:0]  nPC_Sel,
  output logic [2:0]  ALUOp,
  output logic        illegal,
  output logic [31:0] retired,
  output logic [2:0]  state
);

  state_t state_q;
  state_t next_state;
  cls_t   cls;
  logic   dec_illegal;
  logic   final_cycle;

  mc_decode u_decode (
    .op      (Op),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign state = state_q;

  // Next state, control outputs and last-cycle flag; write enables are
  // forced low while reset is held so nothing is written during reset
  always_comb begin
    next_state  = S_FETCH;
    final_cycle = 1'b0;
    PCWr        = 1'b0;
    IRWr        = 1'b0;
    RegWrite    = 1'b0;
    MemWrite    = 1'b0;
    ALUSrc      = 1'b0;
    RegDst      = RD_RT;
    Mem2Reg     = M2R_ALU;
    ExtOp       = EXT_ZERO;
    nPC_Sel     = NPC_PC4;
    ALUOp       = ALU_ADD;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          IRWr       = 1'b1;
          PCWr       = 1'b1;
          nPC_Sel    = NPC_PC4;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        if (cls.j) begin
          PCWr        = 1'b1;
          nPC_Sel     = NPC_J;
          final_cycle = 1'b1;
        end else if (cls.jal) begin
          PCWr        = 1'b1;
          nPC_Sel     = NPC_J;
          RegWrite    = 1'b1;
          RegDst      = RD_RA;
          Mem2Reg     = M2R_PC4;
          final_cycle = 1'b1;
        end else if (cls.jr) begin
          PCWr        = 1'b1;
          nPC_Sel     = NPC_JR;
          final_cycle = 1'b1;
        end else if (dec_illegal) begin
          illegal     = 1'b1;
        end else begin
          next_state  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls.beq) begin
          ALUOp       = ALU_SUB;
          PCWr        = zero;
          nPC_Sel     = NPC_BR;
          final_cycle = 1'b1;
        end else if (cls.addu || cls.subu) begin
          ALUOp       = cls.subu ? ALU_SUB : ALU_ADD;
          next_state  = S_WB;
        end else if (cls.ori || cls.lui) begin
          ALUOp       = ALU_OR;
          ExtOp       = cls.lui ? EXT_LUI : EXT_ZERO;
          ALUSrc      = 1'b1;
          next_state  = S_WB;
        end else if (cls.lw || cls.sw) begin
          ALUOp       = ALU_ADD;
          ExtOp       = EXT_SIGN;
          ALUSrc      = 1'b1;
          next_state  = S_MEM;
        end
      end
      S_MEM: begin
        if (cls.sw) begin
          MemWrite    = 1'b1;
          final_cycle = mem_ready;
          next_state  = mem_ready ? S_FETCH : S_MEM;
        end else if (cls.lw) begin
          next_state  = mem_ready ? S_WB : S_MEM;
        end
      end
      S_WB: begin
        RegWrite    = 1'b1;
        RegDst      = (cls.addu || cls.subu) ? RD_RD : RD_RT;
        Mem2Reg     = cls.lw ? M2R_DM : M2R_ALU;
        final_cycle = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase
    if (!reset) begin
      PCWr        = 1'b0;
      IRWr        = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
      illegal     = 1'b0;
      final_cycle = 1'b0;
    end
  end

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      retired <= 32'd0;
    end else begin
      state_q <= next_state;
      if (final_cycle) retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// the FSM and compares state, packed control outputs and retired count
// against hand-computed values.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  Op;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic        PCWr, IRWr, RegWrite, MemWrite, ALUSrc, illegal;
  logic [1:0]  RegDst, Mem2Reg, ExtOp;
  logic [2:0]  nPC_Sel, ALUOp, state;
  logic [31:0] retired;

  int checks   = 0;
  int failures = 0;

  logic [17:0] ctl_obs;
  logic [17:0] none_c, fetch_c;

  // Clock
  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .PCWr      (PCWr),
    .IRWr      (IRWr),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ALUSrc    (ALUSrc),
    .RegDst    (RegDst),
    .Mem2Reg   (Mem2Reg),
    .ExtOp     (ExtOp),
    .nPC_Sel   (nPC_Sel),
    .ALUOp     (ALUOp),
    .illegal   (illegal),
    .retired   (retired),
    .state     (state)
  );

  assign ctl_obs = {PCWr, IRWr, RegWrite, MemWrite, ALUSrc,
                    RegDst, Mem2Reg, ExtOp, nPC_Sel, ALUOp, illegal};

  // Expected control word builder (same field order as ctl_obs)
  function automatic logic [17:0] pk(input logic pcwr, input logic irwr,
                                     input logic rw, input logic mw,
                                     input logic asrc, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic [1:0] ext,
                                     input logic [2:0] npc, input logic [2:0] alu,
                                     input logic ill);
    return {pcwr, irwr, rw, mw, asrc, rd, m2r, ext, npc, alu, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle (inputs already set at negedge), then advance a cycle
  task automatic step(input string tag, input logic [2:0] st, input logic [17:0] c);
    #1;
    chk({tag, ".state"}, {29'd0, state}, {29'd0, st});
    chk({tag, ".ctl"}, {14'd0, ctl_obs}, {14'd0, c});
    @(negedge clk);
  endtask

  task automatic set_ins(input logic [5:0] o, input logic [5:0] f);
    Op    = o;
    funct = f;
  endtask

  initial begin
    none_c  = '0;
    fetch_c = pk(1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
    reset = 1'b0; mem_ready = 1'b1; zero = 1'b0;
    set_ins(6'h00, 6'h21);

    // Reset state: FETCH, count zero, no enables even with mem_ready=1
    @(negedge clk);
    #1;
    chk("reset.state", {29'd0, state}, 32'd0);
    chk("reset.retired", retired, 32'd0);
    chk("reset.ctl", {14'd0, ctl_obs}, {14'd0, none_c});
    @(negedge clk);
    reset = 1'b1;

    // addu
    step("addu.F", 3'd0, fetch_c);
    step("addu.D", 3'd1, none_c);
    step("addu.E", 3'd2, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    chk("addu.retired_pre", retired, 32'd0);
    step("addu.W", 3'd4, pk(0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    chk("addu.retired", retired, 32'd1);

    // subu
    set_ins(6'h00, 6'h23);
    step("subu.F", 3'd0, fetch_c);
    step("subu.D", 3'd1, none_c);
    step("subu.E", 3'd2, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd1, 0));
    step("subu.W", 3'd4, pk(0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    chk("subu.retired", retired, 32'd2);

    // ori
    set_ins(6'h0D, 6'h3F);
    step("ori.F", 3'd0, fetch_c);
    step("ori.D", 3'd1, none_c);
    step("ori.E", 3'd2, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd2, 0));
    step("ori.W", 3'd4, pk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));

    // lui
    set_ins(6'h0F, 6'h00);
    step("lui.F", 3'd0, fetch_c);
    step("lui.D", 3'd1, none_c);
    step("lui.E", 3'd2, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd2, 3'd0, 3'd2, 0));
    step("lui.W", 3'd4, pk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    chk("lui.retired", retired, 32'd4);

    // lw with two wait cycles in MEM
    set_ins(6'h23, 6'h00);
    step("lw.F", 3'd0, fetch_c);
    step("lw.D", 3'd1, none_c);
    step("lw.E", 3'd2, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 0));
    mem_ready = 1'b0;
    step("lw.M0", 3'd3, none_c);
    step("lw.M1", 3'd3, none_c);
    mem_ready = 1'b1;
    step("lw.M2", 3'd3, none_c);
    step("lw.W", 3'd4, pk(0, 0, 1, 0, 0, 2'd0, 2'd1, 2'd0, 3'd0, 3'd0, 0));
    chk("lw.retired", retired, 32'd5);

    // beq taken and not taken
    set_ins(6'h04, 6'h00);
    zero = 1'b1;
    step("beq1.F", 3'd0, fetch_c);
    step("beq1.D", 3'd1, none_c);
    step("beq1.E", 3'd2, pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd1, 0));
    chk("beq1.retired", retired, 32'd6);
    zero = 1'b0;
    step("beq0.F", 3'd0, fetch_c);
    step("beq0.D", 3'd1, none_c);
    step("beq0.E", 3'd2, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd1, 3'd1, 0));
    chk("beq0.retired", retired, 32'd7);

    // j, jal, jr
    set_ins(6'h02, 6'h00);
    step("j.F", 3'd0, fetch_c);
    step("j.D", 3'd1, pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd2, 3'd0, 0));
    set_ins(6'h03, 6'h00);
    step("jal.F", 3'd0, fetch_c);
    step("jal.D", 3'd1, pk(1, 0, 1, 0, 0, 2'd2, 2'd2, 2'd0, 3'd2, 3'd0, 0));
    set_ins(6'h00, 6'h08);
    step("jr.F", 3'd0, fetch_c);
    step("jr.D", 3'd1, pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd3, 3'd0, 0));
    chk("jr.retired", retired, 32'd10);

    // Illegal opcode and illegal funct
    set_ins(6'h3F, 6'h00);
    step("ill_op.F", 3'd0, fetch_c);
    step("ill_op.D", 3'd1, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1));
    chk("ill_op.retired", retired, 32'd10);
    set_ins(6'h00, 6'h00);
    step("ill_fn.F", 3'd0, fetch_c);
    step("ill_fn.D", 3'd1, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1));
    chk("ill_fn.state", {29'd0, state}, 32'd0);
    chk("ill_fn.retired", retired, 32'd10);

    // Async reset while a sw waits in MEM
    set_ins(6'h2B, 6'h00);
    step("swr.F", 3'd0, fetch_c);
    step("swr.D", 3'd1, none_c);
    step("swr.E", 3'd2, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 0));
    mem_ready = 1'b0;
    #1;
    chk("swr.M.state", {29'd0, state}, 32'd3);
    chk("swr.M.memwrite", {31'd0, MemWrite}, 32'd1);
    reset = 1'b0;
    #1;
    chk("swr.rst.state", {29'd0, state}, 32'd0);
    chk("swr.rst.ctl", {14'd0, ctl_obs}, {14'd0, none_c});
    chk("swr.rst.retired", retired, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Fetch stall, counter preset, then sw completion wraps the count
    force dut.retired = 32'hFFFF_FFFF;
    #1;
    release dut.retired;
    chk("wrap.preset", retired, 32'hFFFF_FFFF);
    @(negedge clk);
    step("stall.F0", 3'd0, none_c);
    step("stall.F1", 3'd0, none_c);
    mem_ready = 1'b1;
    step("sw.F", 3'd0, fetch_c);
    step("sw.D", 3'd1, none_c);
    step("sw.E", 3'd2, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 0));
    mem_ready = 1'b0;
    step("sw.M0", 3'd3, pk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    chk("sw.retired_wait", retired, 32'hFFFF_FFFF);
    mem_ready = 1'b1;
    step("sw.M1", 3'd3, pk(0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0));
    #1;
    chk("sw.state_end", {29'd0, state}, 32'd0);
    chk("sw.retired_wrap", retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: Op  input  6  and funct  input  6; IR fields from the datapath, stable from DECODE until instruction end.
REQ-004 SHALL have port: zero  input  1  ALU equality flag, valid in EXEC.
REQ-005 SHALL have port: mem_ready  input  1  memory handshake; an access completes in a cycle where it is 1.
REQ-006 SHALL have ports: PCWr, IRWr, RegWrite, MemWrite, ALUSrc  output  1 each  write enables and ALU B select.
REQ-007 SHALL have ports: RegDst 2 (0 rt, 1 rd, 2 $31); Mem2Reg 2 (0 ALU, 1 DM, 2 PC+4); ExtOp 2 (0 zero, 1 sign, 2 lui-high) outputs.
REQ-008 SHALL have ports: nPC_Sel 3 (0 PC+4, 1 branch, 2 jump, 3 jr); ALUOp 3 (0 add, 1 sub, 2 or) outputs.
REQ-009 SHALL have ports: illegal  output  1  one-cycle pulse; retired  output  32  completed-instruction count; state  output  3  current state.

Function
REQ-010 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other encodings go to FETCH next cycle, no writes asserted.
REQ-011 SHALL support addu, subu, ori, lui, lw, sw, beq, j, jal, jr; everything else is illegal.
REQ-012 FETCH: mem_ready=1 -> IRWr=1, PCWr=1, nPC_Sel=0, next DECODE; mem_ready=0 -> all enables 0, stay.
REQ-013 DECODE: j -> PCWr=1, nPC_Sel=2, next FETCH; jal -> same plus RegWrite=1, RegDst=2, Mem2Reg=2; jr -> PCWr=1, nPC_Sel=3, next FETCH.
REQ-014 DECODE: illegal opcode/funct -> illegal=1 for that cycle, no enables, next FETCH, retired not incremented; other legal -> EXEC.
REQ-015 EXEC: beq -> ALUOp=1, PCWr=zero, nPC_Sel=1, next FETCH; addu/subu -> ALUOp 0/1, ALUSrc=0, next WB.
REQ-016 EXEC: ori -> ALUOp=2, ExtOp=0, ALUSrc=1; lui -> ALUOp=2, ExtOp=2, ALUSrc=1; both next WB.
REQ-017 EXEC: lw/sw -> ALUOp=0, ExtOp=1, ALUSrc=1, next MEM.
REQ-018 MEM: sw -> MemWrite=1 while waiting; next FETCH on mem_ready=1, else stay. lw -> next WB on mem_ready=1, else stay.
REQ-019 WB: RegWrite=1 one cycle; R-type RegDst=1, Mem2Reg=0; ori/lui RegDst=0, Mem2Reg=0; lw RegDst=0, Mem2Reg=1; next FETCH.
REQ-020 Outputs SHALL be combinational from state, Op, funct, zero and mem_ready; selects not listed for a state are 0.
REQ-021 retired SHALL increment by 1 on every legal instruction's final cycle (j/jal/jr DECODE, beq EXEC, sw MEM with mem_ready=1, WB), wrapping 0xFFFFFFFF -> 0.
REQ-022 At most one instruction in flight; PC written at most twice per instruction (FETCH, then optional redirect).

Reset
REQ-023 reset=0 SHALL force state=FETCH and retired=0 immediately, regardless of clk, including mid-instruction.
REQ-024 During reset, PCWr, IRWr, RegWrite, MemWrite and illegal SHALL be 0; first fetch is the first rising edge with reset=1.

Structure
REQ-025 Shared package mc_defs SHALL hold state encodings, opcode/funct constants and RegDst/Mem2Reg/ExtOp/nPC_Sel/ALUOp encodings.
REQ-026 Combinational sub-module mc_decode SHALL classify Op/funct into one-hot instruction class plus illegal; FSM and counter live in multicycle_ctrl.

Verification
REQ-027 addu with mem_ready=1: states 0,1,2,4,0; RegWrite=1 only in WB with RegDst=1; retired 0->1.
REQ-028 lw, mem_ready low for 2 MEM cycles: states 0,1,2,3,3,3,4,0 (5 instruction cycles + 2 wait = 7); Mem2Reg=1 in WB; no MemWrite.
REQ-029 beq zero=1 -> PCWr=1, nPC_Sel=1 in EXEC; zero=0 -> PCWr=0; both 3 cycles, retired +1 each.
REQ-030 jal: DECODE asserts PCWr, nPC_Sel=2, RegWrite, RegDst=2, Mem2Reg=2; Op=6'h3F -> illegal pulse, retired unchanged.
REQ-031 retired preset to 0xFFFFFFFF then sw completes -> 0; reset=0 asserted in MEM -> state=0 before next edge, MemWrite=0.
